msk_inv_mc_seq: RTL and testbench

Sequencer for the masked inverse MixColumns step of the decryption datapath. It accepts a full masked 128-bit state, serializes it column by column through a single sharewise inverse-MixColumns column unit (4 cycles, one column per cycle) and returns the transformed state with a valid/ready handshake. A per-transaction bypass flag gives the last decryption round, which skips InvMixColumns, the same constant latency.

---
 rtl/msk_inv_mc_seq.sv | 102 ++++++++++
 tb/tb_msk_inv_mc_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/msk_inv_mc_seq.sv
// rtl/msk_inv_mc_seq.sv - masked inverse MixColumns sequencer, one column per cycle
module msk_inv_mc_seq #(
    parameter int d = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_bypass,
    input  logic [128*d-1:0]   in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [128*d-1:0]   out_state,
    output logic               busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          st;
    logic [128*d-1:0]    s;
    logic [1:0]          col;
    logic                byp;
    logic                accept;
    logic [d-1:0][31:0]  sh_in;
    logic [d-1:0][31:0]  sh_out;
    logic [32*d-1:0]     col_nxt;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplications by 9/b/d/e built from xtime, linear over GF(2) so valid per share.
    function automatic logic [31:0] inv_mc(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[8*r +: 8];
            x2    = xt(a[r]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                me[0] ^ mb[1] ^ md[2] ^ m9[3]};
    endfunction

    // Column bit j of share i sits at d*j+i because bytes 0..3 are contiguous.
    for (genvar i = 0; i < d; i++) begin : g_share
        assign sh_out[i] = inv_mc(sh_in[i]);
        for (genvar j = 0; j < 32; j++) begin : g_bit
            assign sh_in[i][j]     = s[d*j + i];
            assign col_nxt[d*j + i] = byp ? s[d*j + i] : sh_out[i][j];
        end
    end

    assign in_ready  = (st == IDLE) || ((st == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (st == DONE);
    assign busy      = (st == BUSY);
    assign out_state = s;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st  <= IDLE;
            s   <= '0;
            col <= 2'd0;
            byp <= 1'b0;
        end else begin
            case (st)
                BUSY: begin
                    s   <= {col_nxt, s[128*d-1:32*d]};
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        st <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        s   <= in_state;
                        byp <= in_bypass;
                        col <= 2'd0;
                        st  <= BUSY;
                    end else if ((st == DONE && out_ready) || st == 2'd3) begin
                        st <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_inv_mc_seq.sv
// tb/tb_msk_inv_mc_seq.sv - scoreboard bench for msk_inv_mc_seq with d=2
module tb_msk_inv_mc_seq;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid;
    logic         in_ready;
    logic         in_bypass;
    logic [255:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_state;
    logic         busy;

    typedef struct {
        logic [255:0] val;
        bit           exact;
    } exp_t;

    exp_t q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [255:0] obs_a, obs_b, st_x, st_y;
    logic [127:0] v;

    msk_inv_mc_seq #(.d(2)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_invmc(input logic [127:0] pv);
        logic [7:0] coef [4];
        logic [127:0] r = '0;
        logic [7:0] acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(pv[8*(4*c+k) +: 8], coef[(k - row + 4) % 4]);
                r[8*(4*c+row) +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [255:0] share(input logic [127:0] pv, input logic [127:0] m);
        logic [255:0] r;
        for (int j = 0; j < 128; j++) begin
            r[2*j]   = m[j];
            r[2*j+1] = pv[j] ^ m[j];
        end
        return r;
    endfunction

    function automatic logic [127:0] recomb(input logic [255:0] sv);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[j] = sv[2*j] ^ sv[2*j+1];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [255:0] sv, input logic byp);
        exp_t e;
        e.exact = byp;
        e.val   = byp ? sv : {128'b0, ref_invmc(recomb(sv))};
        q.push_back(e);
        acc_q.push_back(cyc);
    endtask

    task automatic send(input logic [255:0] sv, input logic byp);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_state = sv; in_bypass = byp;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("send_timeout", 256'd0, 256'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = {rnd128(), rnd128()};
        push(sv, byp);
    endtask

    task automatic recv(input string tag, input bit take, output logic [255:0] obs);
        int n = 0;
        int acc;
        exp_t e;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        obs = out_state;
        if (!out_valid || q.size() == 0) begin
            chk({tag, "_timeout"}, 256'd0, 256'd1);
            return;
        end
        acc = acc_q.pop_front();
        e   = q.pop_front();
        chk({tag, "_lat"}, 256'(cyc - acc), 256'd4);
        if (e.exact) chk({tag, "_data"}, out_state, e.val);
        else         chk({tag, "_data"}, {128'b0, recomb(out_state)}, e.val);
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        nrst = 1'b0; in_valid = 1'b0; in_bypass = 1'b0; in_state = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_out_state", out_state, 256'd0);
        nrst = 1'b1;

        // known vector in column 0
        send(share(128'hbca14d8e, rnd128()), 1'b0);
        chk("busy_high", 256'(busy), 256'd1);
        chk("busy_in_ready", 256'(in_ready), 256'd0);
        recv("vec", 1'b0, obs_a);
        chk("vec_const", {128'b0, recomb(obs_a)}, {128'b0, 128'h455313db});
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        chk("idle_after", 256'(in_ready), 256'd1);

        // all 01 columns, two fresh mask sets
        for (int t = 0; t < 2; t++) begin
            send(share({16{8'h01}}, rnd128()), 1'b0);
            recv("ones", 1'b0, obs_a);
            chk("ones_const", {128'b0, recomb(obs_a)}, {128'b0, {16{8'h01}}});
            out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        end

        // bypass keeps shares bit-identical
        send({rnd128(), rnd128()}, 1'b1);
        recv("byp", 1'b1, obs_a);

        // back-pressure then back-to-back accept
        st_x = share(rnd128(), rnd128());
        send(st_x, 1'b0);
        recv("bp", 1'b0, obs_a);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_state", out_state, obs_a);
            chk("bp_valid", 256'(out_valid), 256'd1);
            chk("bp_in_ready", 256'(in_ready), 256'd0);
        end
        st_y = share(rnd128(), rnd128());
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_state = st_y; in_bypass = 1'b0;
        #1;
        chk("b2b_in_ready", 256'(in_ready), 256'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        push(st_y, 1'b0);
        chk("b2b_busy", 256'(busy), 256'd1);
        recv("b2b", 1'b1, obs_a);

        // abort mid-BUSY
        send(share(rnd128(), rnd128()), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("abort_in_ready", 256'(in_ready), 256'd1);
        chk("abort_out_valid", 256'(out_valid), 256'd0);
        chk("abort_out_state", out_state, 256'd0);
        void'(q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        nrst = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("abort_no_out", 256'(out_valid), 256'd0);
        end

        // flipping every share-1 input bit flips exactly every share-1 output bit
        v = rnd128();
        st_x = share(v, rnd128());
        send(st_x, 1'b0);
        recv("ind_a", 1'b1, obs_a);
        send(st_x ^ {128{2'b10}}, 1'b0);
        recv("ind_b", 1'b1, obs_b);
        chk("indep_share0", (obs_a ^ obs_b) & {128{2'b01}}, 256'd0);
        chk("indep_share1", obs_a ^ obs_b, {128{2'b10}});

        chk("queue_empty", 256'(q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
